uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_CH byte-source FIFOs (e.g. console, debug, DMA transmit queues) using a round-robin policy.
- Pops one byte from the granted FIFO and presents it to the transmitter with a one-cycle tx_enable strobe.
- Tracks the transmitter busy handshake until the byte completes, then re-arbitrates.
- Sits between the per-channel FIFO wrappers and the UART transmitter; status outputs feed the APB status register.

Parameters:
- NUM_CH, 4, number of requesting FIFOs (2..8).
- IDW, $clog2(NUM_CH), width of the channel index.
- BUSY_WAIT_MAX, 15, maximum cycles after tx_enable to wait for busy to assert before declaring a timeout (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ch_empty  in  NUM_CH  per-channel FIFO empty flag
- ch_rdata  in  NUM_CH*8  per-channel FIFO read data; channel k occupies bits [8k+7:8k]; valid the cycle after that channel's ch_ren
- ch_mask  in  NUM_CH  per-channel arbitration enable; 1 = eligible
- ch_ren  out  NUM_CH  per-channel FIFO read enable; one-hot single-cycle pulse
- busy  in  1  UART transmitter busy
- data_in  out  8  byte to the transmitter; 8'hFF except in LOAD
- tx_enable  out  1  single-cycle start strobe to the transmitter
- grant_id  out  IDW  channel currently owning the transmitter
- grant_valid  out  1  high from POP through DRAIN
- timeout_err  out  1  single-cycle pulse when busy fails to assert

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; last_id=NUM_CH-1, so channel 0 has first priority; wait counter=0.
  - Outputs: ch_ren=0, tx_enable=0, data_in=8'hFF, grant_id=0, grant_valid=0, timeout_err=0.
  - Reset mid-transaction abandons the transaction. No further ch_ren or tx_enable pulses are issued until a new grant.
- Request vector: req = ~ch_empty & ch_mask.
- IDLE:
  - If busy==0 and req!=0: pick the first set bit of req scanning last_id+1, last_id+2, ... modulo NUM_CH. Register it as sel and drive it on grant_id. Go to POP.
  - Otherwise stay in IDLE.
  - If busy==1, no grant is made even when requests are pending.
- POP: ch_ren[sel]=1 for exactly one cycle; grant_valid=1. Go to LOAD.
- LOAD:
  - tx_enable=1 for exactly one cycle; data_in=ch_rdata[sel].
  - Clear the wait counter. Go to WAITB.
- WAITB:
  - If busy==1, go to DRAIN.
  - Otherwise increment the counter.
  - When the counter reaches BUSY_WAIT_MAX with busy still 0: pulse timeout_err for one cycle, set last_id=sel, go to IDLE. The byte is considered lost.
- DRAIN:
  - Stay while busy==1.
  - When busy==0: set last_id=sel, go to IDLE.
  - Re-arbitration may grant in the IDLE cycle that immediately follows.
- Latency: grant decision to tx_enable is 2 cycles (IDLE→POP→LOAD). Minimum spacing between tx_enable pulses is 4 cycles plus the busy duration.
- Fairness: a channel that was just served has lowest priority on the next arbitration. With all channels requesting, grant order is 0,1,...,NUM_CH-1,0.
- ch_mask and ch_empty are sampled only in IDLE. Changes during POP..DRAIN do not abort the current transaction.
- This block is the sole reader of each FIFO, so a channel selected in IDLE cannot become empty before POP.
- Outputs are decoded from registered state and sel only. No input-to-output combinational path exists except data_in←ch_rdata in LOAD.

Test Plan:
- Single byte: ch_empty=4'b1101, mask=4'hF, ch 1 FIFO holds 8'hA5; busy rises 1 cycle after tx_enable and is held 10 cycles.
  → ch_ren=4'b0010 for 1 cycle; next cycle tx_enable=1 with data_in=8'hA5; grant_id=1; grant_valid stays high until busy falls.
- Round robin: all four FIFOs hold 3 bytes each, busy model 5 cycles.
  → grant sequence 0,1,2,3,0,1,2,3,0,1,2,3; exactly 12 tx_enable pulses; data matches per-channel FIFO order.
- Masking: all four FIFOs non-empty, mask=4'b1010.
  → only channels 1 and 3 are granted, alternating. Setting mask=4'hF while channel 3 is in DRAIN makes the next grant channel 0.
- Busy held high at idle: busy=1 with requests pending for 20 cycles.
  → no ch_ren or tx_enable. First grant occurs the cycle after busy falls.
- Timeout: transmitter never asserts busy, BUSY_WAIT_MAX=15.
  → timeout_err pulses once, 15 cycles after WAITB entry; FSM returns to IDLE; next grant goes to the following channel.
- Reset mid-operation: assert rst during DRAIN of channel 2.
  → all outputs take reset values asynchronously, data_in=8'hFF. After release with all channels requesting, the first grant is channel 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_CH byte FIFOs.
// Each grant pops one byte, strobes it into the transmitter, then follows busy until the byte has gone out.
module uart_tx_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int IDW           = $clog2(NUM_CH),
  parameter int BUSY_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_empty,
  input  logic [NUM_CH*8-1:0]   ch_rdata,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic [NUM_CH-1:0]     ch_ren,
  input  logic                  busy,
  output logic [7:0]            data_in,
  output logic                  tx_enable,
  output logic [IDW-1:0]        grant_id,
  output logic                  grant_valid,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_WAITB, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_sel, w_sel_nxt;
  logic [IDW-1:0]    r_last_id, w_last_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [NUM_CH-1:0] w_req;
  logic [IDW-1:0]    w_pick, w_idx;
  logic              w_pick_vld;

  assign w_req = ~ch_empty & ch_mask;

  // Scan from the channel after the last one served so it gets lowest priority.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = IDW'((32'(r_last_id) + i) % NUM_CH);
      if (!w_pick_vld && w_req[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_last_id <= IDW'(NUM_CH - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_last_id <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last_id;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!busy && w_pick_vld) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = S_POP;
        end
      end
      S_POP:  w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAITB;
      end
      S_WAITB: begin
        if (busy) begin
          w_state_nxt = S_DRAIN;
        end else if (r_cnt == 8'(BUSY_WAIT_MAX - 1)) begin
          // Transmitter never started: the byte is dropped and arbitration moves on.
          w_timeout_nxt = 1'b1;
          w_last_nxt    = r_sel;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (!busy) begin
          w_last_nxt  = r_sel;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ch_ren = '0;
    if (r_state == S_POP) ch_ren[r_sel] = 1'b1;
  end

  assign data_in     = (r_state == S_LOAD) ? ch_rdata[{r_sel, 3'b000} +: 8] : 8'hFF;
  assign tx_enable   = (r_state == S_LOAD);
  assign grant_id    = r_sel;
  assign grant_valid = (r_state != S_IDLE);
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and transmitter models plus a round-robin reference,
// stepped once per cycle from a single process.
module tb_uart_tx_arbiter;
  localparam int NUM_CH = 4;
  localparam int IDW    = 2;
  localparam int BWM    = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   ch_empty, ch_mask, ch_ren;
  logic [NUM_CH*8-1:0] ch_rdata;
  logic                busy;
  logic [7:0]          data_in;
  logic                tx_enable;
  logic [IDW-1:0]      grant_id;
  logic                grant_valid, timeout_err;

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .IDW(IDW), .BUSY_WAIT_MAX(BWM)) dut (
    .clk(clk), .rst(rst), .ch_empty(ch_empty), .ch_rdata(ch_rdata), .ch_mask(ch_mask),
    .ch_ren(ch_ren), .busy(busy), .data_in(data_in), .tx_enable(tx_enable),
    .grant_id(grant_id), .grant_valid(grant_valid), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    int ch; int exp; logic [7:0] data; logic [7:0] exp_data;
    int gid; logic gv; int ren_cyc; int cyc;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        cur;
  int         to_q[$];
  logic [7:0] fifo [NUM_CH][$];
  int n_chk, n_fail, cyc, proto, m_last, bm_cnt, busy_len, pushed;
  logic bm_arm, busy_m, busy_force, pend;

  // Reference policy: first requester after the last served channel, modulo NUM_CH.
  function automatic int rr(input int last, input logic [NUM_CH-1:0] req);
    for (int i = 1; i <= NUM_CH; i++)
      if (req[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
    return -1;
  endfunction

  task automatic step();
    logic [NUM_CH-1:0] req_e;
    logic busy_e;
    int ch;
    @(negedge clk);
    cyc++;
    req_e  = ~ch_empty & ch_mask;
    busy_e = busy;
    if (ch_ren != '0) begin
      if (!$onehot(ch_ren) || busy_e || pend) proto++;
      ch = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) if (ch_ren[k]) ch = k;
      cur.ch = ch; cur.exp = rr(m_last, req_e); cur.gid = grant_id;
      cur.gv = grant_valid; cur.ren_cyc = cyc;
      if (cur.exp >= 0) m_last = cur.exp;
      if (fifo[ch].size() == 0) begin proto++; cur.exp_data = 8'hFF; end
      else cur.exp_data = fifo[ch].pop_front();
      ch_rdata[8*ch +: 8] = cur.exp_data;
      pend = 1'b1;
    end
    if (tx_enable) begin
      if (!pend || cyc != cur.ren_cyc + 1) proto++;
      cur.data = data_in; cur.cyc = cyc;
      ev_q.push_back(cur);
      pend = 1'b0;
    end
    if (timeout_err) to_q.push_back(cyc);
    // Transmitter: busy is seen high for busy_len cycles starting the cycle after tx_enable.
    if (bm_cnt > 0) begin bm_cnt--; if (bm_cnt == 0) busy_m = 1'b0; end
    if (bm_arm) begin
      bm_arm = 1'b0;
      if (busy_len > 0) begin busy_m = 1'b1; bm_cnt = busy_len; end
    end
    if (tx_enable) bm_arm = 1'b1;
    busy = busy_m | busy_force;
    for (int k = 0; k < NUM_CH; k++) ch_empty[k] = (fifo[k].size() == 0);
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    fifo[ch].push_back(b);
    ch_empty[ch] = 1'b0;
    pushed++;
  endtask

  task automatic run(input int n, input int bound);
    int c = 0;
    while (ev_q.size() < n && c < bound) begin step(); c++; end
  endtask

  task automatic idle_wait();
    int c = 0;
    while ((grant_valid || bm_cnt != 0 || bm_arm || pend) && c < 200) begin step(); c++; end
  endtask

  task automatic reset_model();
    m_last = NUM_CH - 1; pend = 1'b0; bm_cnt = 0; bm_arm = 1'b0; busy_m = 1'b0;
    busy = busy_force;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); reset_model(); rst = 1'b0;
    ev_q.delete(); to_q.delete(); proto = 0;
  endtask

  task automatic test_reset();
    step(); step();
    n_chk++; if (ch_ren !== '0)       begin n_fail++; $display("FAIL reset_ren: got %b want 0", ch_ren); end
    n_chk++; if (tx_enable !== 1'b0)  begin n_fail++; $display("FAIL reset_txen: got %b want 0", tx_enable); end
    n_chk++; if (data_in !== 8'hFF)   begin n_fail++; $display("FAIL reset_data: got %h want ff", data_in); end
    n_chk++; if (grant_id !== '0)     begin n_fail++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_to: got %b want 0", timeout_err); end
    rst = 1'b0; step(); step();
    n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_gv: got %b want 0", grant_valid); end
  endtask

  task automatic test_round_robin();
    do_reset(); busy_len = 5;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < NUM_CH; k++) push(k, 8'($urandom));
    run(12, 600); idle_wait();
    n_chk++; if (ev_q.size() != 12) begin n_fail++; $display("FAIL rr_count: got %0d want 12", ev_q.size()); end
    foreach (ev_q[i]) begin
      n_chk++; if (ev_q[i].ch != i % NUM_CH) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ev_q[i].ch, i % NUM_CH); end
      n_chk++; if (ev_q[i].ch != ev_q[i].exp) begin n_fail++; $display("FAIL rr_model[%0d]: got %0d want %0d", i, ev_q[i].ch, ev_q[i].exp); end
      n_chk++; if (ev_q[i].data !== ev_q[i].exp_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, ev_q[i].data, ev_q[i].exp_data); end
      n_chk++; if (ev_q[i].gid != ev_q[i].ch) begin n_fail++; $display("FAIL rr_gid[%0d]: got %0d want %0d", i, ev_q[i].gid, ev_q[i].ch); end
      if (i > 0) begin
        n_chk++; if (ev_q[i].cyc - ev_q[i-1].cyc != 4 + busy_len) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, ev_q[i].cyc - ev_q[i-1].cyc, 4 + busy_len); end
      end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL rr_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_single();
    int hi = 0;
    ev_q.delete(); proto = 0; busy_len = 10; ch_mask = '1;
    push(1, 8'hA5);
    run(1, 20);
    n_chk++; if (ev_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", ev_q.size()); end
    else begin
      n_chk++; if (ev_q[0].ch != 1) begin n_fail++; $display("FAIL single_ch: got %0d want 1", ev_q[0].ch); end
      n_chk++; if (ev_q[0].data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", ev_q[0].data); end
      n_chk++; if (ev_q[0].gid != 1 || ev_q[0].gv !== 1'b1) begin n_fail++; $display("FAIL single_grant: got id %0d gv %b want id 1 gv 1", ev_q[0].gid, ev_q[0].gv); end
    end
    for (int j = 0; j < busy_len + 1; j++) begin step(); if (grant_valid === 1'b1) hi++; end
    n_chk++; if (hi != busy_len + 1) begin n_fail++; $display("FAIL single_gv_hold: got %0d cycles want %0d", hi, busy_len + 1); end
    step();
    n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_gv_drop: got %b want 0", grant_valid); end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL single_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_masking();
    int c = 0;
    logic done = 1'b0;
    do_reset(); busy_len = $urandom_range(1, 6); ch_mask = 4'b1010;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < NUM_CH; k++) push(k, 8'($urandom));
    while (ev_q.size() < 12 && c < 1500) begin
      step(); c++;
      if (!done && ev_q.size() == 4 && cyc == ev_q[3].cyc + 2) begin ch_mask = '1; done = 1'b1; end
    end
    idle_wait();
    n_chk++; if (ev_q.size() != 12) begin n_fail++; $display("FAIL mask_count: got %0d want 12", ev_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (ev_q[i].ch != ((i % 2 == 0) ? 1 : 3)) begin n_fail++; $display("FAIL mask_alt[%0d]: got %0d want %0d", i, ev_q[i].ch, (i % 2 == 0) ? 1 : 3); end
      end
      n_chk++; if (ev_q[4].ch != 0) begin n_fail++; $display("FAIL mask_unmask: got %0d want 0", ev_q[4].ch); end
    end
    foreach (ev_q[i]) begin
      n_chk++; if (ev_q[i].ch != ev_q[i].exp || ev_q[i].data !== ev_q[i].exp_data) begin n_fail++; $display("FAIL mask_model[%0d]: got ch %0d data %h want ch %0d data %h", i, ev_q[i].ch, ev_q[i].data, ev_q[i].exp, ev_q[i].exp_data); end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL mask_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_busy_idle();
    int fcyc;
    ev_q.delete(); proto = 0; busy_len = $urandom_range(1, 6);
    busy_force = 1'b1; busy = 1'b1;
    for (int k = 0; k < NUM_CH; k++) push(k, 8'($urandom));
    for (int j = 0; j < 20; j++) step();
    n_chk++; if (ev_q.size() != 0 || pend) begin n_fail++; $display("FAIL busy_hold: got %0d tx pend %b want 0 0", ev_q.size(), pend); end
    busy_force = 1'b0; busy = busy_m; fcyc = cyc;
    run(4, 200); idle_wait();
    n_chk++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL busy_count: got %0d want 4", ev_q.size()); end
    else begin
      n_chk++; if (ev_q[0].ren_cyc != fcyc + 1) begin n_fail++; $display("FAIL busy_first_grant: got cycle %0d want %0d", ev_q[0].ren_cyc, fcyc + 1); end
    end
    foreach (ev_q[i]) begin
      n_chk++; if (ev_q[i].ch != ev_q[i].exp || ev_q[i].data !== ev_q[i].exp_data) begin n_fail++; $display("FAIL busy_model[%0d]: got ch %0d data %h want ch %0d data %h", i, ev_q[i].ch, ev_q[i].data, ev_q[i].exp, ev_q[i].exp_data); end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL busy_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_timeout();
    int c = 0;
    ev_q.delete(); to_q.delete(); proto = 0; busy_len = 0;
    for (int k = 0; k < NUM_CH; k++) push(k, 8'($urandom));
    run(4, 300);
    while (to_q.size() < 4 && c < 40) begin step(); c++; end
    idle_wait();
    n_chk++; if (ev_q.size() != 4 || to_q.size() != 4) begin n_fail++; $display("FAIL to_count: got %0d tx %0d timeouts want 4 4", ev_q.size(), to_q.size()); end
    else begin
      foreach (ev_q[i]) begin
        n_chk++; if (to_q[i] != ev_q[i].cyc + 1 + BWM) begin n_fail++; $display("FAIL to_time[%0d]: got cycle %0d want %0d", i, to_q[i], ev_q[i].cyc + 1 + BWM); end
        n_chk++; if (ev_q[i].ch != ev_q[i].exp) begin n_fail++; $display("FAIL to_model[%0d]: got %0d want %0d", i, ev_q[i].ch, ev_q[i].exp); end
        if (i > 0) begin
          n_chk++; if (ev_q[i].ch != (ev_q[i-1].ch + 1) % NUM_CH) begin n_fail++; $display("FAIL to_next[%0d]: got %0d want %0d", i, ev_q[i].ch, (ev_q[i-1].ch + 1) % NUM_CH); end
        end
      end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL to_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_reset_mid();
    ev_q.delete(); proto = 0; busy_len = 10;
    push(2, 8'($urandom));
    run(1, 60);
    step(); step(); step();
    n_chk++; if (ev_q.size() != 1 || grant_id != 2 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got %0d tx id %0d gv %b want 1 tx id 2 gv 1", ev_q.size(), grant_id, grant_valid); end
    for (int k = 0; k < NUM_CH; k++) push(k, 8'($urandom));
    rst = 1'b1;
    #1;
    n_chk++; if (grant_valid !== 1'b0 || grant_id !== '0) begin n_fail++; $display("FAIL rmid_grant: got id %0d gv %b want 0 0", grant_id, grant_valid); end
    n_chk++; if (data_in !== 8'hFF || tx_enable !== 1'b0 || ch_ren !== '0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got data %h tx %b ren %b to %b want ff 0 0 0", data_in, tx_enable, ch_ren, timeout_err); end
    reset_model(); step(); rst = 1'b0;
    ev_q.delete(); proto = 0;
    run(4, 200); idle_wait();
    n_chk++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL rmid_count: got %0d want 4", ev_q.size()); end
    else begin
      n_chk++; if (ev_q[0].ch != 0) begin n_fail++; $display("FAIL rmid_first: got %0d want 0", ev_q[0].ch); end
    end
    foreach (ev_q[i]) begin
      n_chk++; if (ev_q[i].ch != ev_q[i].exp || ev_q[i].data !== ev_q[i].exp_data) begin n_fail++; $display("FAIL rmid_model[%0d]: got ch %0d data %h want ch %0d data %h", i, ev_q[i].ch, ev_q[i].data, ev_q[i].exp, ev_q[i].exp_data); end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL rmid_protocol: got %0d errors want 0", proto); end
  endtask

  task automatic test_random();
    int c = 0;
    ev_q.delete(); proto = 0; pushed = 0;
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(0, NUM_CH - 1);
        if (fifo[k].size() < 4) push(k, 8'($urandom));
      end
      if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) busy_len = $urandom_range(0, 8);
      step();
    end
    ch_mask = '1; busy_len = 3;
    while ((fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size() != 0) && c < 3000) begin step(); c++; end
    idle_wait();
    n_chk++; if (ev_q.size() != pushed) begin n_fail++; $display("FAIL rand_count: got %0d tx want %0d", ev_q.size(), pushed); end
    foreach (ev_q[i]) begin
      n_chk++; if (ev_q[i].ch != ev_q[i].exp || ev_q[i].data !== ev_q[i].exp_data || ev_q[i].gid != ev_q[i].ch) begin n_fail++; $display("FAIL rand_model[%0d]: got ch %0d id %0d data %h want ch %0d data %h", i, ev_q[i].ch, ev_q[i].gid, ev_q[i].data, ev_q[i].exp, ev_q[i].exp_data); end
    end
    n_chk++; if (proto != 0) begin n_fail++; $display("FAIL rand_protocol: got %0d errors want 0", proto); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; proto = 0; pushed = 0;
    busy_force = 1'b0; busy_m = 1'b0; bm_cnt = 0; bm_arm = 1'b0; pend = 1'b0;
    busy_len = 5; busy = 1'b0; m_last = NUM_CH - 1;
    ch_empty = '1; ch_mask = '1; ch_rdata = '1; rst = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_masking();
    test_busy_idle();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
